mcast_router: RTL and testbench

Parametrised per-column multicaster between the X bus and one PE. It has three independent channels: ifmap, filter and psum. Each channel filters incoming bus beats by tag against the column ID, buffers matching beats in its own FIFO, and delivers them to the PE over valid/ready. It also runs a kernel-window counter and a PE-enable state machine. It supersedes the fixed-width, unbuffered multicaster with a configurable-depth, flushable, handshake-correct version.

---
 rtl/mcast_router.sv | 176 +++++++++++++++++
 tb/tb_mcast_router.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcast_router.sv
// mcast_router: per-column multicaster with three tag-filtered FIFO channels, a kernel-window
// counter and a PE-enable FSM. Define MCAST_BROADCAST_EN to accept MSB-tagged broadcast beats.

module mcast_fifo #(
   parameter int W          = 16,
   parameter int IW         = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [IW-1:0] id,
   input  logic [IW:0]   tag,
   input  logic [W-1:0]  b2m_data,
   input  logic          b2m_valid,
   output logic          b2m_ready,
   output logic [W-1:0]  m2p_data,
   output logic          m2p_valid,
   input  logic          m2p_ready,
   output logic          push
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr, rd_ptr;
   logic [W-1:0] mem [FIFO_DEPTH];
   logic         match, full, empty, pop;

`ifdef MCAST_BROADCAST_EN
   assign match = (tag == {1'b0, id}) || tag[IW];
`else
   assign match = (tag == {1'b0, id});
`endif

   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // beats for other columns are acknowledged and dropped so the shared bus never stalls
   assign b2m_ready = rst_n && !flush && (!match || !full);
   assign push      = b2m_valid && b2m_ready && match;
   assign m2p_valid = !empty;
   assign pop       = m2p_valid && m2p_ready && !flush;
   assign m2p_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= b2m_data;
   end
endmodule

module mcast_router #(
   parameter int  DATA_WIDTH = 16,
   parameter int  NUM_COL    = 4,
   parameter int  FIFO_DEPTH = 4,
   localparam int IW         = $clog2(NUM_COL)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [IW-1:0]           id,
   input  logic [IW:0]             ifmap_tag,
   input  logic [DATA_WIDTH-1:0]   ifmap_b2m_data,
   input  logic                    ifmap_b2m_valid,
   output logic                    ifmap_b2m_ready,
   output logic [DATA_WIDTH-1:0]   ifmap_m2p_data,
   output logic                    ifmap_m2p_valid,
   input  logic                    ifmap_m2p_ready,
   input  logic [IW:0]             fltr_tag,
   input  logic [DATA_WIDTH-1:0]   fltr_b2m_data,
   input  logic                    fltr_b2m_valid,
   output logic                    fltr_b2m_ready,
   output logic [DATA_WIDTH-1:0]   fltr_m2p_data,
   output logic                    fltr_m2p_valid,
   input  logic                    fltr_m2p_ready,
   input  logic [IW:0]             psum_tag,
   input  logic [2*DATA_WIDTH-1:0] psum_b2m_data,
   input  logic                    psum_b2m_valid,
   output logic                    psum_b2m_ready,
   output logic [2*DATA_WIDTH-1:0] psum_m2p_data,
   output logic                    psum_m2p_valid,
   input  logic                    psum_m2p_ready,
   input  logic                    flush,
   input  logic [7:0]              kernel_size,
   output logic                    pe_en,
   output logic                    win_done
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   logic [7:0] win_cnt;
   logic       ifmap_push, fltr_push, psum_push;
   logic       any_valid, any_push, ifmap_hs;

   mcast_fifo #(.W(DATA_WIDTH), .IW(IW), .FIFO_DEPTH(FIFO_DEPTH)) u_ifmap (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id(id), .tag(ifmap_tag),
      .b2m_data(ifmap_b2m_data), .b2m_valid(ifmap_b2m_valid), .b2m_ready(ifmap_b2m_ready),
      .m2p_data(ifmap_m2p_data), .m2p_valid(ifmap_m2p_valid), .m2p_ready(ifmap_m2p_ready),
      .push(ifmap_push)
   );

   mcast_fifo #(.W(DATA_WIDTH), .IW(IW), .FIFO_DEPTH(FIFO_DEPTH)) u_fltr (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id(id), .tag(fltr_tag),
      .b2m_data(fltr_b2m_data), .b2m_valid(fltr_b2m_valid), .b2m_ready(fltr_b2m_ready),
      .m2p_data(fltr_m2p_data), .m2p_valid(fltr_m2p_valid), .m2p_ready(fltr_m2p_ready),
      .push(fltr_push)
   );

   mcast_fifo #(.W(2*DATA_WIDTH), .IW(IW), .FIFO_DEPTH(FIFO_DEPTH)) u_psum (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id(id), .tag(psum_tag),
      .b2m_data(psum_b2m_data), .b2m_valid(psum_b2m_valid), .b2m_ready(psum_b2m_ready),
      .m2p_data(psum_m2p_data), .m2p_valid(psum_m2p_valid), .m2p_ready(psum_m2p_ready),
      .push(psum_push)
   );

   assign any_valid = ifmap_m2p_valid || fltr_m2p_valid || psum_m2p_valid;
   assign any_push  = ifmap_push || fltr_push || psum_push;
   assign ifmap_hs  = ifmap_m2p_valid && ifmap_m2p_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         pe_en <= 1'b0;
      end else if (flush) begin
         state <= IDLE;
         pe_en <= 1'b0;
      end else begin
         case (state)
            IDLE: if (any_valid) begin
               state <= BUSY;
               pe_en <= 1'b1;
            end
            BUSY: if (!any_valid && !any_push) begin
               state <= IDLE;
               pe_en <= 1'b0;
            end
            default: begin
               state <= IDLE;
               pe_en <= 1'b0;
            end
         endcase
      end
   end

   // a zero kernel size parks the window counter so win_done never fires
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt  <= '0;
         win_done <= 1'b0;
      end else if (flush) begin
         win_cnt  <= '0;
         win_done <= 1'b0;
      end else begin
         win_done <= 1'b0;
         if (kernel_size == 8'd0) begin
            win_cnt <= '0;
         end else if (ifmap_hs) begin
            if (win_cnt == kernel_size - 8'd1) begin
               win_cnt  <= '0;
               win_done <= 1'b1;
            end else begin
               win_cnt <= win_cnt + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_mcast_router.sv
// Self-checking bench for mcast_router: vector table for tag filtering plus hand-written
// sequences for latency, backpressure, windowing, flush and reset, with a queue scoreboard.

module tb_mcast_router;
   localparam int DW = 16;
   localparam int NC = 4;
   localparam int IW = 2;
   localparam int FD = 4;
`ifdef MCAST_BROADCAST_EN
   localparam logic BC = 1'b1;
`else
   localparam logic BC = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [IW-1:0]   id;
   logic [IW:0]     ifmap_tag, fltr_tag, psum_tag;
   logic [DW-1:0]   ifmap_b2m_data, fltr_b2m_data, ifmap_m2p_data, fltr_m2p_data;
   logic [2*DW-1:0] psum_b2m_data, psum_m2p_data;
   logic            ifmap_b2m_valid, ifmap_b2m_ready, ifmap_m2p_valid, ifmap_m2p_ready;
   logic            fltr_b2m_valid, fltr_b2m_ready, fltr_m2p_valid, fltr_m2p_ready;
   logic            psum_b2m_valid, psum_b2m_ready, psum_m2p_valid, psum_m2p_ready;
   logic            flush;
   logic [7:0]      kernel_size;
   logic            pe_en, win_done;

   always #5 clk = ~clk;

   mcast_router #(.DATA_WIDTH(DW), .NUM_COL(NC), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst_n(rst_n), .id(id),
      .ifmap_tag(ifmap_tag), .ifmap_b2m_data(ifmap_b2m_data), .ifmap_b2m_valid(ifmap_b2m_valid),
      .ifmap_b2m_ready(ifmap_b2m_ready), .ifmap_m2p_data(ifmap_m2p_data),
      .ifmap_m2p_valid(ifmap_m2p_valid), .ifmap_m2p_ready(ifmap_m2p_ready),
      .fltr_tag(fltr_tag), .fltr_b2m_data(fltr_b2m_data), .fltr_b2m_valid(fltr_b2m_valid),
      .fltr_b2m_ready(fltr_b2m_ready), .fltr_m2p_data(fltr_m2p_data),
      .fltr_m2p_valid(fltr_m2p_valid), .fltr_m2p_ready(fltr_m2p_ready),
      .psum_tag(psum_tag), .psum_b2m_data(psum_b2m_data), .psum_b2m_valid(psum_b2m_valid),
      .psum_b2m_ready(psum_b2m_ready), .psum_m2p_data(psum_m2p_data),
      .psum_m2p_valid(psum_m2p_valid), .psum_m2p_ready(psum_m2p_ready),
      .flush(flush), .kernel_size(kernel_size), .pe_en(pe_en), .win_done(win_done)
   );

   int total = 0;
   int bad   = 0;
   int n_if = 0, n_fl = 0, n_ps = 0;
   int hs = 0, pulses = 0;
   logic win_mon = 1'b0;
   logic [DW-1:0]   q_if[$];
   logic [DW-1:0]   q_fl[$];
   logic [2*DW-1:0] q_ps[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic unexpected(input string nm, input logic [31:0] act);
      total++;
      bad++;
      $display("FAIL %s: delivered %0h with nothing expected", nm, act);
   endtask

   function automatic logic tb_match(input logic [IW:0] t);
      return (t == {1'b0, id}) || (BC && t[IW]);
   endfunction

   // scoreboard: push on accepted matching beat, pop and compare on PE handshake
   always @(negedge clk) begin
      if (!rst_n || flush) begin
         q_if.delete();
         q_fl.delete();
         q_ps.delete();
      end else begin
         if (ifmap_m2p_valid && ifmap_m2p_ready) begin
            n_if++;
            if (q_if.size() == 0) unexpected("ifmap_extra", 32'(ifmap_m2p_data));
            else check("ifmap_data", 32'(ifmap_m2p_data), 32'(q_if.pop_front()));
         end
         if (fltr_m2p_valid && fltr_m2p_ready) begin
            n_fl++;
            if (q_fl.size() == 0) unexpected("fltr_extra", 32'(fltr_m2p_data));
            else check("fltr_data", 32'(fltr_m2p_data), 32'(q_fl.pop_front()));
         end
         if (psum_m2p_valid && psum_m2p_ready) begin
            n_ps++;
            if (q_ps.size() == 0) unexpected("psum_extra", psum_m2p_data);
            else check("psum_data", psum_m2p_data, q_ps.pop_front());
         end
         if (ifmap_b2m_valid && ifmap_b2m_ready && tb_match(ifmap_tag)) q_if.push_back(ifmap_b2m_data);
         if (fltr_b2m_valid && fltr_b2m_ready && tb_match(fltr_tag)) q_fl.push_back(fltr_b2m_data);
         if (psum_b2m_valid && psum_b2m_ready && tb_match(psum_tag)) q_ps.push_back(psum_b2m_data);
      end
   end

   always @(negedge clk) begin
      if (win_mon && rst_n && !flush) begin
         if (win_done) begin
            pulses++;
            check("win_pos", 32'(hs), 32'(3 * pulses));
         end
         if (ifmap_m2p_valid && ifmap_m2p_ready) hs++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int ch, input logic v, input logic [IW:0] t, input logic [31:0] d);
      case (ch)
         0: begin ifmap_b2m_valid = v; ifmap_tag = t; ifmap_b2m_data = d[DW-1:0]; end
         1: begin fltr_b2m_valid = v; fltr_tag = t; fltr_b2m_data = d[DW-1:0]; end
         default: begin psum_b2m_valid = v; psum_tag = t; psum_b2m_data = d; end
      endcase
   endtask

   function automatic logic rdy(input int ch);
      return (ch == 0) ? ifmap_b2m_ready : (ch == 1) ? fltr_b2m_ready : psum_b2m_ready;
   endfunction

   function automatic logic mv(input int ch);
      return (ch == 0) ? ifmap_m2p_valid : (ch == 1) ? fltr_m2p_valid : psum_m2p_valid;
   endfunction

   task automatic send(input int ch, input logic [IW:0] t, input logic [31:0] d);
      int k = 0;
      set_in(ch, 1'b1, t, d);
      forever begin
         @(negedge clk);
         if (rdy(ch)) break;
         k++;
         if (k > 200) begin
            unexpected("send_timeout", d);
            break;
         end
      end
      tick();
      set_in(ch, 1'b0, t, d);
   endtask

   task automatic wait_drain(input string nm);
      int k = 0;
      while ((q_if.size() + q_fl.size() + q_ps.size()) != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check(nm, 32'(q_if.size() + q_fl.size() + q_ps.size()), 32'd0);
      tick();
   endtask

   task automatic all_ready(input logic r);
      ifmap_m2p_ready = r;
      fltr_m2p_ready  = r;
      psum_m2p_ready  = r;
   endtask

   typedef struct {
      logic [IW-1:0] id;
      int            ch;
      logic [IW:0]   tag;
      logic [31:0]   data;
      logic          rdy;
      logic          dlv;
   } vec_t;

   vec_t vt[8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      vt[0] = '{2'd1, 1, 3'd3, 32'h0000_BEEF, 1'b1, 1'b0};
      vt[1] = '{2'd1, 1, 3'd4, 32'h0000_0ABC, 1'b1, BC};
      vt[2] = '{2'd1, 1, 3'd1, 32'h0000_1234, 1'b1, 1'b1};
      vt[3] = '{2'd3, 0, 3'd3, 32'h0000_5555, 1'b1, 1'b1};
      vt[4] = '{2'd3, 2, 3'd0, 32'hDEAD_BEEF, 1'b1, 1'b0};
      vt[5] = '{2'd0, 2, 3'd0, 32'hCAFE_F00D, 1'b1, 1'b1};
      vt[6] = '{2'd0, 0, 3'd6, 32'h0000_0606, 1'b1, BC};
      vt[7] = '{2'd2, 1, 3'd7, 32'h0000_7777, 1'b1, BC};

      rst_n = 1'b0; flush = 1'b0; kernel_size = 8'd0; id = 2'd2;
      set_in(0, 1'b1, 3'd2, 32'h1); set_in(1, 1'b1, 3'd2, 32'h2); set_in(2, 1'b1, 3'd2, 32'h3);
      all_ready(1'b1);
      #2;
      check("rst_if_rdy", 32'(ifmap_b2m_ready), 32'd0);
      check("rst_fl_rdy", 32'(fltr_b2m_ready), 32'd0);
      check("rst_ps_rdy", 32'(psum_b2m_ready), 32'd0);
      check("rst_valids", {29'd0, ifmap_m2p_valid, fltr_m2p_valid, psum_m2p_valid}, 32'd0);
      check("rst_ps_data", psum_m2p_data, 32'd0);
      check("rst_pe_en", 32'(pe_en), 32'd0);
      check("rst_win_done", 32'(win_done), 32'd0);
      set_in(0, 1'b0, 3'd0, 32'h0); set_in(1, 1'b0, 3'd0, 32'h0); set_in(2, 1'b0, 3'd0, 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // addressed flow with latency and pe_en timing
      n0 = n_fl;
      set_in(1, 1'b1, 3'd2, 32'h0011);
      @(negedge clk);
      check("af_rdy", 32'(fltr_b2m_ready), 32'd1);
      check("af_v_before", 32'(fltr_m2p_valid), 32'd0);
      check("af_pe_idle", 32'(pe_en), 32'd0);
      tick(); set_in(1, 1'b1, 3'd2, 32'h0022);
      @(negedge clk);
      check("af_latency", 32'(fltr_m2p_valid), 32'd1);
      check("af_pe_early", 32'(pe_en), 32'd0);
      tick(); set_in(1, 1'b1, 3'd2, 32'h0033);
      @(negedge clk);
      check("af_pe_rise", 32'(pe_en), 32'd1);
      tick(); set_in(1, 1'b0, 3'd2, 32'h0);
      wait_drain("af_drain");
      for (int k = 0; k < 10 && pe_en; k++) tick();
      check("af_pe_fall", 32'(pe_en), 32'd0);
      check("af_count", 32'(n_fl - n0), 32'd3);

      // tag filtering and broadcast vectors
      for (int i = 0; i < 8; i++) begin
         id = vt[i].id;
         set_in(vt[i].ch, 1'b1, vt[i].tag, vt[i].data);
         @(negedge clk);
         check($sformatf("vec%0d_rdy", i), 32'(rdy(vt[i].ch)), 32'(vt[i].rdy));
         tick();
         set_in(vt[i].ch, 1'b0, vt[i].tag, vt[i].data);
         @(negedge clk);
         check($sformatf("vec%0d_dlv", i), 32'(mv(vt[i].ch)), 32'(vt[i].dlv));
         tick(); tick();
      end

      // backpressure: full FIFO refuses, then drains without gaps
      id = 2'd1; psum_m2p_ready = 1'b0; n0 = n_ps;
      for (int i = 1; i <= 4; i++) send(2, 3'd1, 32'(i));
      set_in(2, 1'b1, 3'd1, 32'd5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_full_rdy", 32'(psum_b2m_ready), 32'd0);
         check("bp_head_hold", psum_m2p_data, 32'd1);
         tick();
      end
      fork
         begin
            send(2, 3'd1, 32'd5);
            send(2, 3'd1, 32'd6);
         end
         begin
            psum_m2p_ready = 1'b1;
            for (int i = 0; i < 6; i++) begin
               @(negedge clk);
               if (i == 0) check("bp_full_pop_rdy", 32'(psum_b2m_ready), 32'd0);
               check("bp_nogap", 32'(psum_m2p_valid), 32'd1);
            end
         end
      join
      wait_drain("bp_drain");
      check("bp_count", 32'(n_ps - n0), 32'd6);

      // window counter, kernel_size 3 then 0
      id = 2'd0; hs = 0; pulses = 0; win_mon = 1'b1; kernel_size = 8'd3;
      for (int i = 0; i < 7; i++) send(0, 3'd0, 32'(16'h100 + i));
      wait_drain("win_drain7");
      for (int i = 0; i < 2; i++) send(0, 3'd0, 32'(16'h200 + i));
      wait_drain("win_drain9");
      tick(); tick();
      check("win_pulses", 32'(pulses), 32'd3);
      hs = 0; pulses = 0; kernel_size = 8'd0;
      for (int i = 0; i < 7; i++) send(0, 3'd0, 32'(16'h300 + i));
      wait_drain("win0_drain");
      tick(); tick();
      check("win0_pulses", 32'(pulses), 32'd0);
      win_mon = 1'b0;

      // flush with a colliding new beat
      id = 2'd1; all_ready(1'b0);
      for (int i = 0; i < 2; i++) begin
         send(0, 3'd1, 32'(16'hA0 + i));
         send(1, 3'd1, 32'(16'hB0 + i));
         send(2, 3'd1, 32'(16'hC0 + i));
      end
      n0 = n_if + n_fl + n_ps;
      flush = 1'b1;
      set_in(1, 1'b1, 3'd1, 32'h0099);
      @(negedge clk);
      check("fl_if_rdy", 32'(ifmap_b2m_ready), 32'd0);
      check("fl_fl_rdy", 32'(fltr_b2m_ready), 32'd0);
      check("fl_ps_rdy", 32'(psum_b2m_ready), 32'd0);
      tick();
      flush = 1'b0;
      set_in(1, 1'b0, 3'd1, 32'h0);
      @(negedge clk);
      check("fl_valids", {29'd0, ifmap_m2p_valid, fltr_m2p_valid, psum_m2p_valid}, 32'd0);
      check("fl_pe_en", 32'(pe_en), 32'd0);
      check("fl_rdy_back", 32'(fltr_b2m_ready), 32'd1);
      tick();
      all_ready(1'b1);
      for (int i = 0; i < 4; i++) tick();
      check("fl_no_deliv", 32'(n_if + n_fl + n_ps - n0), 32'd0);

      // asynchronous reset mid-stream
      all_ready(1'b0);
      for (int i = 0; i < 2; i++) begin
         send(0, 3'd1, 32'(16'hD0 + i));
         send(1, 3'd1, 32'(16'hE0 + i));
         send(2, 3'd1, 32'(16'hF0 + i));
      end
      set_in(2, 1'b1, 3'd1, 32'hAAAA_5555);
      n0 = n_if + n_fl + n_ps;
      rst_n = 1'b0;
      #1;
      check("mr_ps_rdy", 32'(psum_b2m_ready), 32'd0);
      check("mr_valids", {29'd0, ifmap_m2p_valid, fltr_m2p_valid, psum_m2p_valid}, 32'd0);
      check("mr_if_data", 32'(ifmap_m2p_data), 32'd0);
      check("mr_fl_data", 32'(fltr_m2p_data), 32'd0);
      check("mr_ps_data", psum_m2p_data, 32'd0);
      check("mr_pe_en", 32'(pe_en), 32'd0);
      check("mr_win_done", 32'(win_done), 32'd0);
      tick();
      rst_n = 1'b1;
      set_in(2, 1'b0, 3'd1, 32'h0);
      all_ready(1'b1);
      for (int i = 0; i < 4; i++) tick();
      check("mr_no_deliv", 32'(n_if + n_fl + n_ps - n0), 32'd0);
      n0 = n_fl;
      send(1, 3'd1, 32'h4242);
      wait_drain("mr_recover_drain");
      check("mr_recover", 32'(n_fl - n0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
